writeback_unit: RTL
===================

Name: writeback_unit

Overview:
Execute/writeback stage directly downstream of the ALU. It accepts one ALU result per handshake. It owns the W register and the full 8-bit STATUS register, and feeds both back to the ALU a-operand and status inputs. It issues file-register writes over a valid/ready port and implements the PIC skip mechanism, which squashes the next instruction.

Parameters:
FADDR_W, 5, file-register address width
STATUS_ADDR, 5'h03, file address mapped to the internal STATUS register (never sent to file port)
W_RESET, 8'h00, W reset value
STATUS_RESET, 8'h18, STATUS reset value (TO=PD=1, Z=DC=C=0)

Ports:
clk_in  in  1  clock
rst_n_in  in  1  synchronous active-low reset
valid_in  in  1  ALU result valid
ready_out  out  1  stage can accept
result_in  in  8  ALU result_out
status_in  in  status_t  ALU status_out
status_update_in  in  1  ALU status_update_out
skip_flag_in  in  1  ALU skip_flag_out
wb_en_in  in  1  instruction writes a destination
dest_w_in  in  1  1=W, 0=file register
f_addr_in  in  FADDR_W  destination file address
w_out  out  8  W register (to ALU a_in)
status_flags_out  out  status_t  STATUS[2:0] as status_t (to ALU status_in)
status_reg_out  out  8  full STATUS (to file read mux)
fw_valid_out  out  1  file write request
fw_addr_out  out  FADDR_W  file write address
fw_data_out  out  8  file write data
fw_ready_in  in  1  file write accepted
skip_pending_out  out  1  next accepted instruction will be squashed
retire_out  out  1  1-cycle pulse, instruction committed
squashed_out  out  1  1-cycle pulse, instruction discarded

Behaviour:
- Clock and reset: one clock, clk_in. Reset is synchronous and active-low on rst_n_in.
- Reset values: W=W_RESET; STATUS=STATUS_RESET; fw_valid_out=0; fw_addr_out=0; fw_data_out=0; skip_pending_out=0; retire_out=0; squashed_out=0.
- Reset mid-operation: a pending file write is dropped, not completed.
- ready_out (combinational) = ~fw_valid_out | fw_ready_in.
- Accept: valid_in & ready_out & rst_n_in.
- FSM: the 4 states {RUN, SKIP, WR_PEND, WR_PEND_SKIP} are the product of two flags, fw_valid_out and skip_pending.
- Squashed accept (skip_pending=1):
  - no W, STATUS or file update;
  - skip_flag_in ignored;
  - skip_pending cleared;
  - squashed_out pulses the next cycle.
- Normal accept (skip_pending=0), all effects registered and visible the cycle after accept (1-cycle latency):
  - status_update_in=1: STATUS[2:0] <= {status_in.zero_flag, status_in.dc_flag, status_in.c_flag} (bit2 Z, bit1 DC, bit0 C).
  - wb_en_in & dest_w_in: W <= result_in.
  - wb_en_in & ~dest_w_in & f_addr_in==STATUS_ADDR: STATUS[7:3] <= result_in[7:3]. STATUS[2:0] <= result_in[2:0] only if status_update_in=0; otherwise the ALU flags win. No file write is issued.
  - wb_en_in & ~dest_w_in & other address: fw_valid_out<=1, fw_addr_out<=f_addr_in, fw_data_out<=result_in.
  - skip_flag_in=1: skip_pending<=1.
  - retire_out pulses.
- File port:
  - fw_addr_out/fw_data_out are held stable while fw_valid_out=1 & fw_ready_in=0.
  - fw_valid_out clears on fw_ready_in unless a new write is loaded the same cycle.
  - Accept in the same cycle as fw_ready_in: the new write replaces the old one, back-to-back with no bubble.
- Squash scope: exactly one accepted instruction is squashed, regardless of idle cycles in between. A squashed instruction cannot arm a further skip.
- No internal forwarding. The ALU sees updated W/STATUS from the cycle after accept; upstream must not accept the next instruction in the same cycle.

Decomposition:
- icepic_lib_pkg gains:
  - STATUS_C_BIT=0, STATUS_DC_BIT=1, STATUS_Z_BIT=2;
  - STATUS_ADDR default constant;
  - wb_state_t enum;
  - function status_merge(old8, result8, status_t, update, is_status_write) returning the next STATUS.
- status_t is reused unchanged.
- No sub-module; single module with a next-state always_comb and one always_ff.

Test Plan:
1. Reset: after rst_n_in low for 2 cycles, expect w_out=00, status_reg_out=18, fw_valid_out=0, ready_out=1.
2. ADDWF to W: result 8'h00, status_in Z=1 DC=1 C=1, update=1, dest_w=1 -> next cycle w_out=00, status_reg_out=1F, retire_out=1, no fw_valid_out.
3. File write with backpressure: dest_w=0, addr 5'h10, data A5, fw_ready_in=0 for 3 cycles -> fw_valid_out=1 with addr 10/data A5 stable, ready_out=0; ready_out=1 and fw_valid_out drops after fw_ready_in=1.
4. Write to STATUS: result FF, addr 03, update=1 with Z=0 DC=0 C=0 -> status_reg_out=F8, no file write. Repeat with update=0 -> FF.
5. Skip: accept with skip_flag=1, then 2 idle cycles, then a W write of 55 -> W unchanged, squashed_out=1, skip_pending_out=0. The following W write of 66 -> w_out=66.
6. Reset mid-write: fw_valid_out=1, fw_ready_in=0, assert rst_n_in=0 for 1 cycle -> fw_valid_out=0, skip_pending_out=0, W/STATUS at reset values.

Source files
------------

// File: rtl/icepic_lib_pkg.sv
// icepic_lib_pkg: shared types, STATUS bit positions and the STATUS next-value helper.
package icepic_lib_pkg;
  typedef struct packed {
    logic zero_flag;
    logic dc_flag;
    logic c_flag;
  } status_t;
  localparam int STATUS_C_BIT = 0;
  localparam int STATUS_DC_BIT = 1;
  localparam int STATUS_Z_BIT = 2;
  localparam logic [4:0] STATUS_ADDR = 5'h03;
  typedef enum logic [1:0] {
    RUN          = 2'b00,
    SKIP         = 2'b01,
    WR_PEND      = 2'b10,
    WR_PEND_SKIP = 2'b11
  } wb_state_t;
  // ALU flags override the low bits of a direct STATUS write when both happen together
  function automatic logic [7:0] status_merge(input logic [7:0] old8, input logic [7:0] result8,
                                              input status_t flags, input logic update,
                                              input logic is_status_write);
    logic [7:0] s;
    s = is_status_write ? result8 : old8;
    if (update) begin
      s[STATUS_Z_BIT] = flags.zero_flag;
      s[STATUS_DC_BIT] = flags.dc_flag;
      s[STATUS_C_BIT] = flags.c_flag;
    end
    return s;
  endfunction
endpackage

// File: rtl/writeback_unit.sv
// writeback_unit: owns W and STATUS, issues file-register writes and squashes skipped instructions.
module writeback_unit
  import icepic_lib_pkg::*;
#(
  parameter int FADDR_W = 5,
  parameter logic [FADDR_W-1:0] STATUS_ADDR_P = FADDR_W'(STATUS_ADDR),
  parameter logic [7:0] W_RESET = 8'h00,
  parameter logic [7:0] STATUS_RESET = 8'h18
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               valid_in,
  output logic               ready_out,
  input  logic [7:0]         result_in,
  input  status_t            status_in,
  input  logic               status_update_in,
  input  logic               skip_flag_in,
  input  logic               wb_en_in,
  input  logic               dest_w_in,
  input  logic [FADDR_W-1:0] f_addr_in,
  output logic [7:0]         w_out,
  output status_t            status_flags_out,
  output logic [7:0]         status_reg_out,
  output logic               fw_valid_out,
  output logic [FADDR_W-1:0] fw_addr_out,
  output logic [7:0]         fw_data_out,
  input  logic               fw_ready_in,
  output logic               skip_pending_out,
  output logic               retire_out,
  output logic               squashed_out
);
  wb_state_t state_q, state_d;
  logic [7:0] w_q, w_d, status_q, status_d, fw_data_q, fw_data_d;
  logic [FADDR_W-1:0] fw_addr_q, fw_addr_d;
  logic retire_q, retire_d, squashed_q, squashed_d;
  logic accept, normal, is_file, is_status, fw_load;
  assign ready_out = ~state_q[1] | fw_ready_in;
  always_comb begin
    accept = valid_in & ready_out;
    normal = accept & ~state_q[0];
    is_file = wb_en_in & ~dest_w_in;
    is_status = is_file & (f_addr_in == STATUS_ADDR_P);
    fw_load = normal & is_file & ~is_status;
    w_d = (normal & wb_en_in & dest_w_in) ? result_in : w_q;
    status_d = normal ? status_merge(status_q, result_in, status_in, status_update_in, is_status) : status_q;
    fw_addr_d = fw_load ? f_addr_in : fw_addr_q;
    fw_data_d = fw_load ? result_in : fw_data_q;
    state_d = wb_state_t'({fw_load | (state_q[1] & ~fw_ready_in),
                           accept ? (normal & skip_flag_in) : state_q[0]});
    retire_d = normal;
    squashed_d = accept & state_q[0];
  end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q <= RUN;
      w_q <= W_RESET;
      status_q <= STATUS_RESET;
      fw_addr_q <= '0;
      fw_data_q <= '0;
      retire_q <= 1'b0;
      squashed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q <= w_d;
      status_q <= status_d;
      fw_addr_q <= fw_addr_d;
      fw_data_q <= fw_data_d;
      retire_q <= retire_d;
      squashed_q <= squashed_d;
    end
  end
  assign w_out = w_q;
  assign status_reg_out = status_q;
  assign status_flags_out = status_t'(status_q[2:0]);
  assign fw_valid_out = state_q[1];
  assign skip_pending_out = state_q[0];
  assign fw_addr_out = fw_addr_q;
  assign fw_data_out = fw_data_q;
  assign retire_out = retire_q;
  assign squashed_out = squashed_q;
endmodule
